// File: rtl/fifth_data_bus.sv
// Data-bus responder for the fifth CPU core.
// Decodes each word access into on-chip data RAM (0x0000-0xEFFF) or a small
// I/O page at 0xF000 holding an 8N1 UART transmitter, a free-running 16-bit
// cycle timer and an 8-bit LED register. Read data is registered (1 cycle).
module fifth_data_bus #(
    parameter int unsigned RAM_ADDR_BITS = 12,
    parameter int unsigned CLKS_PER_BIT  = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] mem_address,
    input  logic        mem_write_enable,
    input  logic [15:0] mem_data_in,
    output logic [15:0] mem_data_out,
    output logic        uart_tx,
    output logic [7:0]  led
);

    localparam logic [15:0] IO_BASE     = 16'hF000;
    localparam logic [15:0] UART_DATA   = 16'hF000;
    localparam logic [15:0] UART_STATUS = 16'hF001;
    localparam logic [15:0] TIMER       = 16'hF002;
    localparam logic [15:0] LED_REG     = 16'hF003;

    localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } uart_state_t;

    logic [15:0]              ram [0:(2**RAM_ADDR_BITS)-1];
    logic [RAM_ADDR_BITS-1:0] ram_idx;
    logic                     is_ram;
    logic [15:0]              timer;

    uart_state_t              state;
    logic [CNT_W-1:0]         clk_cnt;
    logic [2:0]               bit_idx;
    logic [7:0]               shreg;
    logic                     busy;
    logic                     uart_start;

    assign ram_idx    = mem_address[RAM_ADDR_BITS-1:0];
    assign is_ram     = (mem_address < IO_BASE);
    assign busy       = (state != S_IDLE);
    // Writes arriving while a frame is in flight (including its last STOP cycle) are dropped.
    assign uart_start = mem_write_enable && (mem_address == UART_DATA) && !busy;

    // RAM write port; no reset on contents, but writes on a reset edge are suppressed.
    always_ff @(posedge clk) begin
        if (!reset && mem_write_enable && is_ram) begin
            ram[ram_idx] <= mem_data_in;
        end
    end

    // Registered read mux; all sources are sampled before this edge's writes land.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_data_out <= '0;
        end else if (is_ram) begin
            mem_data_out <= ram[ram_idx];
        end else begin
            case (mem_address)
                UART_STATUS: mem_data_out <= {15'b0, busy};
                TIMER:       mem_data_out <= timer;
                LED_REG:     mem_data_out <= {8'b0, led};
                default:     mem_data_out <= '0;
            endcase
        end
    end

    // Free-running timer with CPU load, plus the LED register.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= '0;
            led   <= '0;
        end else begin
            if (mem_write_enable && (mem_address == TIMER)) begin
                timer <= mem_data_in;
            end else begin
                timer <= timer + 16'd1;
            end
            if (mem_write_enable && (mem_address == LED_REG)) begin
                led <= mem_data_in[7:0];
            end
        end
    end

    // UART transmitter: START, 8 data bits LSB first, STOP; each CLKS_PER_BIT cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            uart_tx <= 1'b1;
            clk_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    uart_tx <= 1'b1;
                    clk_cnt <= '0;
                    if (uart_start) begin
                        shreg   <= mem_data_in[7:0];
                        uart_tx <= 1'b0;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        uart_tx <= shreg[0];
                        state   <= S_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= S_STOP;
                        end else begin
                            // The next bit is shifted down so it always comes from shreg[1].
                            bit_idx <= bit_idx + 3'd1;
                            uart_tx <= shreg[1];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt <= '0;
                        state   <= S_IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifth_data_bus.sv
// Testbench for fifth_data_bus: directed scenarios plus a randomized phase,
// all checked against a cycle-indexed behavioural model of the bus.
module tb_fifth_data_bus;

    localparam int unsigned C = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mem_address;
    logic        mem_write_enable;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out;
    logic        uart_tx;
    logic [7:0]  led;

    int unsigned tests = 0;
    int unsigned fails = 0;

    fifth_data_bus #(.RAM_ADDR_BITS(12), .CLKS_PER_BIT(C)) dut (
        .clk              (clk),
        .reset            (reset),
        .mem_address      (mem_address),
        .mem_write_enable (mem_write_enable),
        .mem_data_in      (mem_data_in),
        .mem_data_out     (mem_data_out),
        .uart_tx          (uart_tx),
        .led              (led)
    );

    always #5 clk = ~clk;

    // Model state: everything is expressed as a function of the edge number n.
    int unsigned n = 0;
    logic [15:0] m_ram [0:4095];
    bit          m_ok  [0:4095];
    logic [7:0]  m_led = '0;
    logic [15:0] t_base = '0;
    int unsigned t_load = 0;
    bit          u_act = 0;
    int unsigned u_start = 0;
    logic [7:0]  u_byte = '0;

    function automatic bit busy_after(input int unsigned k);
        return u_act && (k >= u_start) && ((k - u_start) < 10 * C);
    endfunction

    function automatic logic [15:0] timer_after(input int unsigned k);
        return t_base + 16'(k - t_load);
    endfunction

    function automatic logic tx_after(input int unsigned k);
        int unsigned b;
        if (!busy_after(k)) return 1'b1;
        b = (k - u_start) / C;
        if (b == 0) return 1'b0;
        if (b <= 8) return u_byte[b-1];
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive, clock, advance model, check all outputs.
    task automatic cyc(input logic rst, input logic [15:0] a, input logic we, input logic [15:0] d);
        logic [15:0] exp_dout;
        bit          known;
        reset = rst; mem_address = a; mem_write_enable = we; mem_data_in = d;
        @(posedge clk);
        n++;
        known = 1;
        exp_dout = '0;
        if (rst) begin
            m_led = '0; t_base = '0; t_load = n; u_act = 0;
        end else begin
            if (a < 16'hF000) begin
                known = m_ok[a[11:0]];
                exp_dout = m_ram[a[11:0]];
            end else if (a == 16'hF001) exp_dout = {15'b0, busy_after(n - 1)};
            else if (a == 16'hF002) exp_dout = timer_after(n - 1);
            else if (a == 16'hF003) exp_dout = {8'b0, m_led};
            if (we) begin
                if (a < 16'hF000) begin
                    m_ram[a[11:0]] = d; m_ok[a[11:0]] = 1;
                end else if (a == 16'hF000) begin
                    if (!busy_after(n - 1)) begin
                        u_act = 1; u_start = n; u_byte = d[7:0];
                    end
                end else if (a == 16'hF002) begin
                    t_base = d; t_load = n;
                end else if (a == 16'hF003) m_led = d[7:0];
            end
        end
        #1;
        if (known) chk("dout", 64'(mem_data_out), 64'(exp_dout));
        chk("uart_tx", 64'(uart_tx), 64'(tx_after(n)));
        chk("led", 64'(led), 64'(m_led));
    endtask

    initial begin
        logic [9:0]  seq;
        logic [39:0] got_pat;
        logic [39:0] exp_pat;
        int unsigned ones;
        logic [15:0] ra;
        int unsigned r;

        for (int i = 0; i < 4096; i++) m_ok[i] = 0;

        // Reset with a RAM write presented: must be ignored.
        cyc(1, 16'h0005, 1, 16'hDEAD);
        cyc(1, 16'hF004, 0, 16'h0000);
        chk("rst_tx", 64'(uart_tx), 64'h1);
        chk("rst_dout", 64'(mem_data_out), 64'h0);

        // RAM write, read, alias read.
        cyc(0, 16'h0005, 1, 16'h1234);
        cyc(0, 16'h0005, 0, 16'h0000);
        chk("ram_rd", 64'(mem_data_out), 64'h1234);
        cyc(0, 16'h1005, 0, 16'h0000);
        chk("ram_alias", 64'(mem_data_out), 64'h1234);

        // Read-before-write on the same edge.
        cyc(0, 16'h0010, 1, 16'h1111);
        cyc(0, 16'h0010, 1, 16'hBEEF);
        chk("rbw_old", 64'(mem_data_out), 64'h1111);
        cyc(0, 16'h0010, 0, 16'h0000);
        chk("rbw_new", 64'(mem_data_out), 64'hBEEF);

        // UART frame 0x55 with a dropped mid-frame write of 0xAA.
        seq = 10'b1010101010;
        for (int i = 0; i < 40; i++) exp_pat[i] = seq[i / C];
        cyc(0, 16'hF000, 1, 16'h0055);
        got_pat[0] = uart_tx;
        ones = 0;
        for (int i = 1; i < 40; i++) begin
            if (i == 12) cyc(0, 16'hF000, 1, 16'h00AA);
            else cyc(0, 16'hF001, 0, 16'h0000);
            got_pat[i] = uart_tx;
            if (i != 12 && mem_data_out == 16'h0001) ones++;
        end
        chk("frame55", 64'(got_pat), 64'(exp_pat));
        chk("busy_count", 64'(ones), 64'd38);
        cyc(0, 16'hF000, 1, 16'h0033);   // lands on the STOP-complete edge: dropped
        chk("stop_edge_tx", 64'(uart_tx), 64'h1);
        cyc(0, 16'hF001, 0, 16'h0000);
        chk("status_idle", 64'(mem_data_out), 64'h0);
        cyc(0, 16'hF000, 1, 16'h000F);   // first IDLE cycle: accepted
        chk("restart_tx", 64'(uart_tx), 64'h0);
        for (int i = 0; i < 42; i++) cyc(0, 16'hF001, 0, 16'h0000);

        // Timer wrap and LED.
        cyc(0, 16'hF002, 1, 16'hFFFE);
        cyc(0, 16'hF002, 0, 16'h0000);
        chk("tmr0", 64'(mem_data_out), 64'hFFFE);
        cyc(0, 16'hF002, 0, 16'h0000);
        chk("tmr1", 64'(mem_data_out), 64'hFFFF);
        cyc(0, 16'hF002, 0, 16'h0000);
        chk("tmr2", 64'(mem_data_out), 64'h0000);
        cyc(0, 16'hF003, 1, 16'h00A5);
        chk("led_a5", 64'(led), 64'hA5);
        cyc(0, 16'hF004, 0, 16'h0000);
        chk("unmapped", 64'(mem_data_out), 64'h0);

        // Reset 12 cycles into a frame, with a RAM write presented on the reset edge.
        cyc(0, 16'hF000, 1, 16'h005A);
        for (int i = 0; i < 11; i++) cyc(0, 16'hF004, 0, 16'h0000);
        cyc(1, 16'h0005, 1, 16'hDEAD);
        chk("mid_rst_tx", 64'(uart_tx), 64'h1);
        chk("mid_rst_led", 64'(led), 64'h0);
        cyc(0, 16'hF002, 0, 16'h0000);
        chk("rst_timer", 64'(mem_data_out), 64'h0);
        cyc(0, 16'hF001, 0, 16'h0000);
        chk("rst_status", 64'(mem_data_out), 64'h0);
        cyc(0, 16'h0005, 0, 16'h0000);
        chk("ram_kept", 64'(mem_data_out), 64'h1234);

        // Randomized traffic over a 16-word RAM window, the I/O page and unmapped space.
        for (int i = 0; i < 16; i++) cyc(0, 16'(i), 1, 16'($urandom));
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 7);
            if (r < 4) ra = {4'($urandom_range(0, 14)), 8'h00, 4'($urandom_range(0, 15))};
            else if (r < 7) ra = 16'hF000 + 16'($urandom_range(0, 4));
            else ra = 16'hF005 + 16'($urandom_range(0, 16'h0FFA));
            cyc(($urandom_range(0, 63) == 0), ra, 1'($urandom_range(0, 1)), 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
